fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync.sv | 129 ++++++++++++
 tb/tb_fifo_sync.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Single-clock FIFO with status flags, sticky overflow/underflow and optional first-word-fall-through.
// Latency: FWFT=0 read data one cycle after an accepted read; FWFT=1 word visible the cycle after its write.
// Backpressure: writes to a full FIFO (without a same-cycle read) and reads on empty are dropped and flagged.
module fifo_sync #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter int FWFT            = 0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_en,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_rd_en,
    input  logic                          i_flush,
    input  logic                          i_clr_err,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_almost_full,
    output logic                          o_almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;

    logic rd_acc;
    logic wr_acc;
    logic rd_do;
    logic wr_do;
    logic wr_rej;
    logic rd_rej;

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // flush and reset cancel both sides and never count as errors.
    always_comb begin
        rd_acc = i_rd_en && (count != '0);
        wr_acc = i_wr_en && ((count != DEPTH_C) || rd_acc);
        rd_do  = rd_acc && !i_flush && !i_reset;
        wr_do  = wr_acc && !i_flush && !i_reset;
        wr_rej = i_wr_en && !wr_acc && !i_flush;
        rd_rej = i_rd_en && !rd_acc && !i_flush;
    end

    always_comb begin
        count_nxt = count;
        if (i_reset || i_flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_do, rd_do})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + 1'b1;
            if (rd_do) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Flags are registered from the next count so they always agree with o_count.
    always_ff @(posedge i_clk) begin
        count          <= count_nxt;
        o_full         <= (count_nxt == DEPTH_C);
        o_empty        <= (count_nxt == '0);
        o_almost_full  <= (int'(count_nxt) >= ALMOST_FULL_TH);
        o_almost_empty <= (int'(count_nxt) <= ALMOST_EMPTY_TH);
    end

    assign o_count = count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= wr_rej || (o_overflow  && !i_clr_err);
            o_underflow <= rd_rej || (o_underflow && !i_clr_err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_do) mem[wr_ptr] <= i_wr_data;
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_do;
                    if (rd_do) rd_data_q <= mem[rd_ptr];
                end
            end

            assign o_rd_data  = rd_data_q;
            assign o_rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Head word is masked while empty so stale memory never leaks out after reset or flush.
            assign o_rd_data  = o_empty ? '0 : mem[rd_ptr];
            assign o_rd_valid = !o_empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a standard-read and a FWFT instance share stimulus (depth 4, thresholds 2/1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fifo_sync;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] a_rd_data, b_rd_data;
    logic       a_rd_valid, b_rd_valid;
    logic       a_full, a_empty, a_afull, a_aempty;
    logic       b_full, b_empty, b_afull, b_aempty;
    logic [2:0] a_count, b_count;
    logic       a_ovf, a_udf, b_ovf, b_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_sync #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ALMOST_FULL_TH(2), .ALMOST_EMPTY_TH(1), .FWFT(0)) dut_std (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .i_flush(flush), .i_clr_err(clr_err), .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid),
        .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_afull), .o_almost_empty(a_aempty),
        .o_count(a_count), .o_overflow(a_ovf), .o_underflow(a_udf)
    );

    fifo_sync #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ALMOST_FULL_TH(2), .ALMOST_EMPTY_TH(1), .FWFT(1)) dut_fwft (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
        .i_flush(flush), .i_clr_err(clr_err), .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid),
        .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_afull), .o_almost_empty(b_aempty),
        .o_count(b_count), .o_overflow(b_ovf), .o_underflow(b_udf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        step();
        step();
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", a_empty); end
        checks++; if (a_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b expected 1", a_aempty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", a_full); end
        checks++; if (a_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", a_afull); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", a_rd_data); end
        checks++; if ({a_ovf, a_udf} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {a_ovf, a_udf}); end
        checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwft_valid: got %b expected 0", b_rd_valid); end
        idle();
        step();
    endtask

    task automatic test_basic();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = words[i];
            step();
            idle();
            checks++; if (a_count !== 3'(i + 1)) begin errors++; $display("FAIL basic_wr_count%0d: got %0d expected %0d", i, a_count, i + 1); end
            checks++; if (a_afull !== (i >= 1)) begin errors++; $display("FAIL basic_afull%0d: got %b expected %b", i, a_afull, i >= 1); end
            checks++; if (a_aempty !== (i == 0)) begin errors++; $display("FAIL basic_aempty%0d: got %b expected %b", i, a_aempty, i == 0); end
        end
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL basic_full: got %b expected 1", a_full); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            idle();
            checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid%0d: got %b expected 1", i, a_rd_valid); end
            checks++; if (a_rd_data !== words[i]) begin errors++; $display("FAIL basic_rd_data%0d: got %h expected %h", i, a_rd_data, words[i]); end
            checks++; if (a_count !== 3'(3 - i)) begin errors++; $display("FAIL basic_rd_count%0d: got %0d expected %0d", i, a_count, 3 - i); end
        end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b expected 1", a_empty); end
        step();
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 8'h44) begin errors++; $display("FAIL basic_data_hold: got %h expected 44", a_rd_data); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
            step();
        end
        wr_en = 1'b1; wr_data = 8'h99;
        step();
        idle();
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", a_ovf); end
        checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", a_count); end
        clr_err = 1'b1;
        step();
        idle();
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", a_ovf); end
        wr_en = 1'b1; wr_data = 8'h98; clr_err = 1'b1;
        step();
        idle();
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_collide: got %b expected 1", a_ovf); end
        step();
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", a_ovf); end
        clr_err = 1'b1;
        step();
        idle();
    endtask

    task automatic test_full_rw();
        logic [7:0] exp [4];
        exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'h55;
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
        step();
        idle();
        checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL fullrw_count: got %0d expected 4", a_count); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fullrw_ovf: got %b expected 0", a_ovf); end
        checks++; if (a_rd_data !== 8'h11) begin errors++; $display("FAIL fullrw_data: got %h expected 11", a_rd_data); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            idle();
            checks++; if (a_rd_data !== exp[i]) begin errors++; $display("FAIL fullrw_drain%0d: got %h expected %h", i, a_rd_data, exp[i]); end
        end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty: got %b expected 1", a_empty); end
    endtask

    task automatic test_empty_rw();
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        step();
        idle();
        checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL emptyrw_udf: got %b expected 1", a_udf); end
        checks++; if (a_count !== 3'd1) begin errors++; $display("FAIL emptyrw_count: got %0d expected 1", a_count); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL emptyrw_valid: got %b expected 0", a_rd_valid); end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (a_rd_data !== 8'hAA) begin errors++; $display("FAIL emptyrw_data: got %h expected aa", a_rd_data); end
        checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL emptyrw_rvalid: got %b expected 1", a_rd_valid); end
        clr_err = 1'b1;
        step();
        idle();
        checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL emptyrw_udf_clr: got %b expected 0", a_udf); end
    endtask

    task automatic test_fwft();
        reset = 1'b1;
        step();
        idle();
        wr_en = 1'b1; wr_data = 8'h7E;
        step();
        idle();
        checks++; if (b_rd_data !== 8'h7E) begin errors++; $display("FAIL fwft_data: got %h expected 7e", b_rd_data); end
        checks++; if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid: got %b expected 1", b_rd_valid); end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b expected 1", b_empty); end
        checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_valid_drop: got %b expected 0", b_rd_valid); end
        wr_en = 1'b1; wr_data = 8'h01;
        step();
        wr_data = 8'h02;
        step();
        idle();
        checks++; if (b_rd_data !== 8'h01) begin errors++; $display("FAIL fwft_head: got %h expected 01", b_rd_data); end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (b_rd_data !== 8'h02) begin errors++; $display("FAIL fwft_next: got %h expected 02", b_rd_data); end
        checks++; if (b_count !== 3'd1) begin errors++; $display("FAIL fwft_count: got %0d expected 1", b_count); end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (b_rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_drained: got %b expected 0", b_rd_valid); end
    endtask

    task automatic test_wrap_flush();
        reset = 1'b1;
        step();
        idle();
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL wrap_udf_pre: got %b expected 1", a_udf); end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            step();
            idle();
            rd_en = 1'b1;
            step();
            idle();
            checks++; if (a_rd_data !== 8'(8'h30 + i)) begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, a_rd_data, 8'(8'h30 + i)); end
        end
        wr_en = 1'b1; wr_data = 8'hC1;
        step();
        wr_data = 8'hC2;
        step();
        idle();
        checks++; if (a_count !== 3'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", a_count); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        idle();
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", a_count); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", a_empty); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", a_rd_valid); end
        checks++; if ({a_ovf, a_udf} !== 2'b01) begin errors++; $display("FAIL flush_errs: got %b expected 01", {a_ovf, a_udf}); end
        wr_en = 1'b1; wr_data = 8'h5A;
        step();
        idle();
        checks++; if (a_count !== 3'd1) begin errors++; $display("FAIL flush_after_count: got %0d expected 1", a_count); end
        rd_en = 1'b1;
        step();
        idle();
        checks++; if (a_rd_data !== 8'h5A) begin errors++; $display("FAIL flush_after_data: got %h expected 5a", a_rd_data); end
        wr_en = 1'b1; wr_data = 8'h66;
        step();
        wr_data = 8'h77;
        step();
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h88;
        step();
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", a_count); end
        checks++; if ({a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin errors++; $display("FAIL midrst_flags: got %b expected 1100", {a_empty, a_aempty, a_full, a_afull}); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", a_rd_data); end
        checks++; if ({a_ovf, a_udf} !== 2'b00) begin errors++; $display("FAIL midrst_errs: got %b expected 00", {a_ovf, a_udf}); end
        checks++; if ({b_rd_valid, b_rd_data} !== 9'h000) begin errors++; $display("FAIL midrst_fwft: got %h expected 000", {b_rd_valid, b_rd_data}); end
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_wrap_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
